// File: rtl/norm_sched_if.sv
// Bundles the requester-side and engine-side signals of the normal-CDF scheduler.
// The slave modport is the scheduler's view of the bundle.
// The master modport is the view of whatever drives the requests and the engine.
`timescale 1ns/1ps
interface norm_sched_if #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_d;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [WIDTH-1:0]      resp_N;
    logic                  resp_err;
    logic                  err_sticky;
    logic                  eng_start;
    logic [WIDTH-1:0]      eng_d;
    logic [WIDTH-1:0]      eng_N;
    logic                  eng_done;

    modport slave (
        input  req_valid, req_d, eng_N, eng_done,
        output req_ready, resp_valid, resp_N, resp_err, err_sticky, eng_start, eng_d
    );

    modport master (
        output req_valid, req_d, eng_N, eng_done,
        input  req_ready, resp_valid, resp_N, resp_err, err_sticky, eng_start, eng_d
    );
endinterface

// File: rtl/norm_sched.sv
// Round-robin scheduler sharing one normal-CDF engine between NREQ requesters.
// It grants one request at a time, pulses the engine's start signal and waits for done.
// A watchdog bounds the wait on done.
// The result, or a timeout error, is returned to the granted requester.
`timescale 1ns/1ps
module norm_sched #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           reset,   // synchronous, active-low
    norm_sched_if.slave    bus
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    rr_ptr_reg;
    logic [PW-1:0]    gnt_reg;
    logic [15:0]      cnt_reg;
    logic [WIDTH-1:0] eng_d_reg;
    logic [WIDTH-1:0] resp_n_reg;
    logic             resp_err_reg;
    logic             err_sticky_reg;

    logic [NREQ-1:0]  rot_req;      // requests rotated so index 0 is rr_ptr
    logic [NREQ-1:0]  win_onehot;
    logic [NREQ-1:0]  gnt_onehot;
    logic [WIDTH-1:0] req_op [NREQ];
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic             timeout_hit;

    // Per-requester operand slicing, rotation and one-hot decodes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            logic [PW-1:0] src_idx;
            assign src_idx        = PW'((int'(rr_ptr_reg) + gi) % NREQ);
            assign req_op[gi]     = bus.req_d[gi*WIDTH +: WIDTH];
            assign rot_req[gi]    = bus.req_valid[src_idx];
            assign win_onehot[gi] = win_found && (win_idx == PW'(gi));
            assign gnt_onehot[gi] = (gnt_reg == PW'(gi));
        end
    endgenerate

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(rr_ptr_reg) + k) % NREQ);
            end
        end
    end

    // The last WAIT cycle allowed is the TIMEOUT-th one.
    assign timeout_hit = (cnt_reg == 16'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; a done in the expiry cycle still counts as success.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_found) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus.eng_done || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes and grants; all forced low while reset is asserted.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.eng_start  = 1'b0;
        if (reset) begin
            case (state_reg)
                IDLE:    bus.req_ready  = win_onehot;
                ISSUE:   bus.eng_start  = 1'b1;
                RESP:    bus.resp_valid = gnt_onehot;
                default: ;
            endcase
        end
    end

    // Datapath: operand capture, watchdog, result capture and pointer advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_reg     <= '0;
            gnt_reg        <= '0;
            cnt_reg        <= '0;
            eng_d_reg      <= '0;
            resp_n_reg     <= '0;
            resp_err_reg   <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        eng_d_reg <= req_op[win_idx];
                        gnt_reg   <= win_idx;
                    end
                end
                ISSUE: cnt_reg <= '0;
                WAIT: begin
                    if (bus.eng_done) begin
                        resp_n_reg   <= bus.eng_N;
                        resp_err_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                        if (timeout_hit) begin
                            resp_n_reg     <= '0;
                            resp_err_reg   <= 1'b1;
                            err_sticky_reg <= 1'b1;
                        end
                    end
                end
                RESP: rr_ptr_reg <= (gnt_reg == PW'(NREQ - 1)) ? '0 : gnt_reg + PW'(1);
                default: ;
            endcase
        end
    end

    assign bus.eng_d      = eng_d_reg;
    assign bus.resp_N     = resp_n_reg;
    assign bus.resp_err   = resp_err_reg;
    assign bus.err_sticky = err_sticky_reg;
endmodule

// File: tb/tb_norm_sched.sv
// Bench for norm_sched with a mock engine of programmable latency or hang.
// The reference model predicts grant order and response timing from the round-robin rules.
// It pushes each expected response into a queue, which a separate monitor pops and checks.
`timescale 1ns/1ps
module tb_norm_sched;
    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          lane;
        logic [31:0] n;
        logic        err;
        int          cyc;
        logic        sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    norm_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    norm_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus and model state.
    logic        tb_rst = 1'b0;
    logic [NREQ-1:0] tb_valid = '0;
    logic [NREQ-1:0] keep_mask = '0;
    logic [31:0] tb_d [NREQ];
    int          rr_m = 0;
    int          free_m = 0;
    logic        sticky_m = 1'b0;
    int          lat_m = 5;
    logic        hang_m = 1'b0;
    int          exp_start_cyc = -1;
    logic [31:0] exp_start_d = '0;
    exp_t        exp_q[$];
    int          seen_q[$];

    function automatic logic [31:0] fmock(input logic [31:0] d);
        if (d == 32'd0) return 32'h0000_8000;
        return (d ^ 32'hA5A5_0F0F) + 32'd17;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Mock engine: done goes high L cycles after start and is held until the next start.
    logic        eng_done_m = 1'b0;
    logic [31:0] eng_n_m = '0;
    logic [31:0] eng_d_cap = '0;
    int          eng_cnt = 0;
    assign bus.eng_done = eng_done_m;
    assign bus.eng_N    = eng_n_m;

    always @(posedge clk) begin
        if (!rst_n) begin
            eng_done_m <= 1'b0;
            eng_n_m    <= '0;
            eng_cnt    <= 0;
        end else if (bus.eng_start) begin
            eng_done_m <= 1'b0;
            eng_n_m    <= $urandom;
            eng_d_cap  <= bus.eng_d;
            if (hang_m) begin
                eng_cnt <= 0;
            end else if (lat_m == 1) begin
                eng_done_m <= 1'b1;
                eng_n_m    <= fmock(bus.eng_d);
                eng_cnt    <= 0;
            end else begin
                eng_cnt <= lat_m - 1;
            end
        end else if (eng_cnt == 1) begin
            eng_done_m <= 1'b1;
            eng_n_m    <= fmock(eng_d_cap);
            eng_cnt    <= 0;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    // One cycle: drive inputs, let the model decide on a grant, check req_ready.
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        int granted;
        @(negedge clk);
        rst_n = tb_rst;
        bus.req_valid = tb_valid;
        for (int i = 0; i < NREQ; i++) bus.req_d[i*WIDTH +: WIDTH] = tb_d[i];
        #1;
        exp_ready = '0;
        granted = -1;
        if (!tb_rst) begin
            exp_q.delete();
            rr_m = 0;
            sticky_m = 1'b0;
            free_m = cyc + 1;
            exp_start_cyc = -1;
        end else if (cyc >= free_m && tb_valid != '0) begin
            exp_t e;
            for (int k = 0; k < NREQ; k++) begin
                int l;
                l = (rr_m + k) % NREQ;
                if (granted < 0 && tb_valid[l]) granted = l;
            end
            exp_ready[granted] = 1'b1;
            e.lane = granted;
            e.err  = hang_m;
            e.n    = hang_m ? 32'd0 : fmock(tb_d[granted]);
            e.cyc  = cyc + 2 + (hang_m ? TIMEOUT : lat_m);
            if (hang_m) sticky_m = 1'b1;
            e.sticky = sticky_m;
            exp_q.push_back(e);
            exp_start_cyc = cyc + 1;
            exp_start_d = tb_d[granted];
            free_m = e.cyc + 1;
            rr_m = (granted + 1) % NREQ;
        end
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        if (granted >= 0) begin
            if (keep_mask[granted]) tb_d[granted] = $urandom;
            else tb_valid[granted] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || cyc + 1 < free_m) && n < maxc) begin
            step();
            n++;
        end
        check("drain_scoreboard", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: checks engine start pulses and pops the scoreboard on every response.
    always @(negedge clk) begin
        #2;
        if (bus.eng_start || cyc == exp_start_cyc) begin
            check("eng_start_cycle", 64'(bus.eng_start && cyc == exp_start_cyc), 64'd1);
            check("eng_d", 64'(bus.eng_d), 64'(exp_start_d));
        end
        if (bus.resp_valid != '0) begin
            int lane = -1;
            for (int i = 0; i < NREQ; i++) if (bus.resp_valid[i]) lane = i;
            seen_q.push_back(lane);
            $display("resp lane=%0d N=%h err=%b sticky=%b cycle=%0d",
                     lane, bus.resp_N, bus.resp_err, bus.err_sticky, cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_resp_valid", 64'(bus.resp_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_valid_lane", 64'(bus.resp_valid), 64'(1) << e.lane);
                check("resp_cycle", 64'(cyc), 64'(e.cyc));
                check("resp_N", 64'(bus.resp_N), 64'(e.n));
                check("resp_err", 64'(bus.resp_err), 64'(e.err));
                check("err_sticky", 64'(bus.err_sticky), 64'(e.sticky));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish before 1ms");
        $fatal(1, "bench timed out");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) tb_d[i] = '0;
        bus.req_valid = '0;
        bus.req_d = '0;

        // Reset: outputs must be quiet, then all registers read back zero.
        tb_rst = 1'b0;
        repeat (3) step();
        tb_rst = 1'b1;
        step();
        check("rst_eng_d", 64'(bus.eng_d), 64'd0);
        check("rst_resp_N", 64'(bus.resp_N), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_err_sticky", 64'(bus.err_sticky), 64'd0);

        // Single request on lane 0 with d=0, L=5.
        lat_m = 5;
        tb_d[0] = 32'd0;
        tb_valid = 4'b0001;
        step();
        wait_idle(100);

        // Simultaneous requests straight after a reset.
        tb_rst = 1'b0;
        step();
        tb_rst = 1'b1;
        for (int i = 0; i < NREQ; i++) tb_d[i] = 32'h1000_0000 * (i + 1) + $urandom_range(0, 65535);
        tb_valid = '1;
        step();
        wait_idle(200);

        // Fairness: lanes 1 and 3 held valid continuously.
        seen_q.delete();
        keep_mask = 4'b1010;
        tb_d[1] = $urandom;
        tb_d[3] = $urandom;
        tb_valid = 4'b1010;
        begin
            int n = 0;
            while (seen_q.size() < 8 && n < 300) begin
                step();
                n++;
            end
        end
        keep_mask = '0;
        tb_valid = '0;
        wait_idle(100);
        check("fair_count", 64'(seen_q.size() >= 8), 64'd1);
        for (int i = 0; i < 8 && i < seen_q.size(); i++)
            check("fair_order", 64'(seen_q[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

        // Timeout, then good responses with err_sticky still set.
        hang_m = 1'b1;
        tb_d[0] = $urandom;
        tb_valid = 4'b0001;
        step();
        wait_idle(100);
        hang_m = 1'b0;
        tb_d[2] = $urandom;
        tb_d[0] = $urandom;
        tb_valid = 4'b0101;
        step();
        wait_idle(100);
        check("sticky_hold", 64'(bus.err_sticky), 64'd1);

        // Reset in WAIT: lane 2 completes first so the pointer moves to lane 3.
        lat_m = 10;
        tb_d[2] = $urandom;
        tb_valid = 4'b0100;
        step();
        wait_idle(100);
        tb_d[3] = $urandom;
        tb_valid = 4'b1000;
        step();
        repeat (4) step();
        tb_rst = 1'b0;
        tb_d[2] = $urandom;
        tb_d[3] = $urandom;
        tb_valid = 4'b1100;
        step();
        tb_rst = 1'b1;
        lat_m = 5;
        step();
        check("midrst_eng_d", 64'(bus.eng_d), 64'd0);
        check("midrst_resp_N", 64'(bus.resp_N), 64'd0);
        check("midrst_err_sticky", 64'(bus.err_sticky), 64'd0);
        wait_idle(100);

        // Minimum latency.
        lat_m = 1;
        tb_d[1] = $urandom;
        tb_valid = 4'b0010;
        step();
        wait_idle(100);

        // Randomized traffic with varying latency, occasional hangs and drops.
        repeat (500) begin
            if (exp_q.size() == 0 && cyc + 1 >= free_m) begin
                lat_m = $urandom_range(1, 8);
                hang_m = ($urandom_range(0, 9) == 0);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!tb_valid[i] && $urandom_range(0, 3) == 0) begin
                    tb_valid[i] = 1'b1;
                    tb_d[i] = $urandom;
                end else if (tb_valid[i] && $urandom_range(0, 19) == 0) begin
                    tb_valid[i] = 1'b0;
                end
            end
            step();
        end
        tb_valid = '0;
        wait_idle(200);
        hang_m = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
